free_list: RTL and testbench

Physical-register free list for the 2-wide out-of-order core: a 64-entry circular FIFO of free physical-register tags. It hands up to two new destination tags per cycle to dispatch (ROB/map-table side) and accepts up to two freed tags per cycle from ROB retirement. An architectural head pointer supports single-cycle rollback of speculative allocations on flush.

---
 rtl/free_list.sv | 99 +++++++++
 tb/tb_free_list.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list: 64-entry circular FIFO of free physical tags.
// Dispatch peeks up to two tags per cycle (zero-latency) and pops them;
// retirement pushes up to two freed tags per cycle. An architectural head
// pointer tracks the oldest unretired allocation so a flush can roll back
// every speculative pop in a single cycle.
//
// Handshake: there is no valid/ready pair. fl_cap is the "ready" side and
// tells dispatch how many tags it may take this cycle. Requests above fl_cap
// are clamped silently. Retire pushes are always attempted. A push that finds
// the list full is dropped and latches fl_overflow until reset.
module free_list #(
  parameter int DEPTH    = 64,
  parameter int NUM_ARCH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] id_dispatch_num,
  input  logic [1:0] fl_retire_num,
  input  logic [6:0] fl_retire_tag_a,
  input  logic [6:0] fl_retire_tag_b,
  input  logic       flush,
  output logic [6:0] fl_pr0,
  output logic [6:0] fl_pr1,
  output logic [1:0] fl_cap,
  output logic [6:0] fl_free_count,
  output logic       fl_overflow
);

  localparam logic [6:0] NO_TAG = 7'h7f;
  localparam logic [6:0] FULL   = 7'(DEPTH);

  // Pointers: bit 6 is the wrap bit, bits 5:0 index the entry array.
  logic [6:0] entry_q [DEPTH];
  logic [6:0] head_q, head_d;
  logic [6:0] arch_head_q, arch_head_d;
  logic [6:0] tail_q, tail_d;
  logic       overflow_q, overflow_d;

  logic [1:0] disp_n, ret_n, pop_n, push_n;
  logic [6:0] count, count_after_pop, space;
  logic [5:0] head_idx1, tail_idx1;

  // Occupancy and combinational peek of the two oldest free tags.
  always_comb begin
    count     = tail_q - head_q;
    head_idx1 = head_q[5:0] + 6'd1;
    tail_idx1 = tail_q[5:0] + 6'd1;
    fl_pr0        = (count >= 7'd1) ? entry_q[head_q[5:0]] : NO_TAG;
    fl_pr1        = (count >= 7'd2) ? entry_q[head_idx1]   : NO_TAG;
    fl_cap        = (count >= 7'd2) ? 2'd2 : count[1:0];
    fl_free_count = count;
    fl_overflow   = overflow_q;
  end

  // Clamp requests, size pops and pushes, and compute next pointers.
  always_comb begin
    disp_n = (id_dispatch_num == 2'b11) ? 2'd2 : id_dispatch_num;
    ret_n  = (fl_retire_num == 2'b11) ? 2'd2 : fl_retire_num;

    // A flush discards this cycle's dispatch.
    if (flush)
      pop_n = 2'd0;
    else if ({5'd0, disp_n} > count)
      pop_n = count[1:0];
    else
      pop_n = disp_n;

    // Push room is measured after this cycle's pops have left.
    count_after_pop = count - {5'd0, pop_n};
    space           = FULL - count_after_pop;
    push_n          = ({5'd0, ret_n} > space) ? space[1:0] : ret_n;

    // Every retire releases one allocation, whether or not its push fits.
    arch_head_d = arch_head_q + {5'd0, ret_n};
    head_d      = flush ? arch_head_d : head_q + {5'd0, pop_n};
    tail_d      = tail_q + {5'd0, push_n};
    overflow_d  = overflow_q | (push_n != ret_n);
  end

  // Pointer, overflow and entry-array registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= 7'd0;
      arch_head_q <= 7'd0;
      tail_q      <= FULL;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        entry_q[i] <= 7'(NUM_ARCH + i);
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      overflow_q  <= overflow_d;
      if (push_n >= 2'd1) entry_q[tail_q[5:0]] <= fl_retire_tag_a;
      if (push_n == 2'd2) entry_q[tail_idx1]   <= fl_retire_tag_b;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed and randomised bench for free_list. A queue-based reference model
// holds the free tags in FIFO order and the tags allocated since the
// architectural point. Expected dispatch tags go into a scoreboard queue when
// dispatch is driven and are popped and compared against fl_pr0/fl_pr1.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] id_dispatch_num = 2'd0;
  logic [1:0] fl_retire_num = 2'd0;
  logic [6:0] fl_retire_tag_a = 7'd0;
  logic [6:0] fl_retire_tag_b = 7'd0;
  logic       flush = 1'b0;
  logic [6:0] fl_pr0, fl_pr1, fl_free_count;
  logic [1:0] fl_cap;
  logic       fl_overflow;

  free_list dut (
    .clock           (clock),
    .reset           (reset),
    .id_dispatch_num (id_dispatch_num),
    .fl_retire_num   (fl_retire_num),
    .fl_retire_tag_a (fl_retire_tag_a),
    .fl_retire_tag_b (fl_retire_tag_b),
    .flush           (flush),
    .fl_pr0          (fl_pr0),
    .fl_pr1          (fl_pr1),
    .fl_cap          (fl_cap),
    .fl_free_count   (fl_free_count),
    .fl_overflow     (fl_overflow)
  );

  // Clock.
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] m_free  [$];
  logic [6:0] m_alloc [$];
  bit         m_over;
  logic [6:0] exp_q   [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_free.delete();
    m_alloc.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) m_free.push_back(7'(32 + i));
    m_over = 0;
  endtask

  task automatic drive_idle();
    id_dispatch_num = 2'd0;
    fl_retire_num   = 2'd0;
    fl_retire_tag_a = 7'd0;
    fl_retire_tag_b = 7'd0;
    flush           = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive_idle();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Compare every peek output against the model.
  task automatic check_peek();
    int sz;
    sz = m_free.size();
    check("pr0",   {1'b0, fl_pr0}, {1'b0, (sz >= 1) ? m_free[0] : 7'h7f});
    check("pr1",   {1'b0, fl_pr1}, {1'b0, (sz >= 2) ? m_free[1] : 7'h7f});
    check("cap",   {6'd0, fl_cap}, 8'((sz >= 2) ? 2 : sz));
    check("count", {1'b0, fl_free_count}, 8'(sz));
    check("count_le_64", {7'd0, fl_free_count <= 7'd64}, 8'd1);
    check("ovf",   {7'd0, fl_overflow}, {7'd0, m_over});
  endtask

  // Settle with idle inputs and sample away from the rising edge.
  task automatic settle();
    @(negedge clock);
    drive_idle();
    #1;
  endtask

  // One cycle of stimulus: drive, check peek and scoreboard, update model.
  task automatic step(input int disp, input int rn, input logic [6:0] ta,
                      input logic [6:0] tb, input bit fl);
    int dn, r, pn;
    logic [6:0] obs;
    @(negedge clock);
    id_dispatch_num = 2'(disp);
    fl_retire_num   = 2'(rn);
    fl_retire_tag_a = ta;
    fl_retire_tag_b = tb;
    flush           = fl;
    #1;
    check_peek();
    dn = (disp == 3) ? 2 : disp;
    r  = (rn == 3) ? 2 : rn;
    pn = fl ? 0 : ((dn < m_free.size()) ? dn : m_free.size());
    for (int k = 0; k < pn; k++) exp_q.push_back(m_free[k]);
    for (int k = 0; k < pn; k++) begin
      obs = (k == 0) ? fl_pr0 : fl_pr1;
      check("pop_tag", {1'b0, obs}, {1'b0, exp_q.pop_front()});
    end
    for (int k = 0; k < pn; k++) m_alloc.push_back(m_free.pop_front());
    for (int k = 0; k < r; k++) begin
      if (m_free.size() < 64) m_free.push_back((k == 0) ? ta : tb);
      else m_over = 1;
    end
    for (int k = 0; k < r; k++)
      if (m_alloc.size() > 0) void'(m_alloc.pop_front());
    if (fl)
      while (m_alloc.size() > 0) m_free.push_front(m_alloc.pop_back());
    @(posedge clock);
  endtask

  initial begin
    int d, r, mr;
    bit f;
    logic [6:0] ta, tb;

    // Reset and idle: constant reset state.
    do_reset();
    settle();
    check("rst_pr0",   {1'b0, fl_pr0}, 8'd32);
    check("rst_pr1",   {1'b0, fl_pr1}, 8'd33);
    check("rst_cap",   {6'd0, fl_cap}, 8'd2);
    check("rst_count", {1'b0, fl_free_count}, 8'd64);
    check("rst_ovf",   {7'd0, fl_overflow}, 8'd0);

    // Allocate every free tag two at a time.
    for (int i = 0; i < 32; i++) step(2, 0, 7'd0, 7'd0, 1'b0);
    settle();
    check("empty_count", {1'b0, fl_free_count}, 8'd0);
    check("empty_cap",   {6'd0, fl_cap}, 8'd0);
    check("empty_pr0",   {1'b0, fl_pr0}, 8'h7f);
    check("empty_pr1",   {1'b0, fl_pr1}, 8'h7f);

    // Dispatch at empty (including the 2'b11 encoding) pops nothing.
    step(2, 0, 7'd0, 7'd0, 1'b0);
    step(3, 0, 7'd0, 7'd0, 1'b0);
    settle();
    check("empty_hold", {1'b0, fl_free_count}, 8'd0);

    // Refill to one, then dispatch 2 while retiring 5 and 6.
    step(0, 1, 7'd40, 7'd0, 1'b0);
    settle();
    check("one_pr0", {1'b0, fl_pr0}, 8'd40);
    step(2, 2, 7'd5, 7'd6, 1'b0);
    settle();
    check("drain_count", {1'b0, fl_free_count}, 8'd2);
    check("drain_pr0",   {1'b0, fl_pr0}, 8'd5);
    check("drain_pr1",   {1'b0, fl_pr1}, 8'd6);

    // Rollback: six allocations, two retire, then flush.
    do_reset();
    for (int i = 0; i < 3; i++) step(2, 0, 7'd0, 7'd0, 1'b0);
    step(0, 2, 7'd3, 7'd4, 1'b0);
    step(0, 0, 7'd0, 7'd0, 1'b1);
    settle();
    check("flush_pr0",   {1'b0, fl_pr0}, 8'd34);
    check("flush_pr1",   {1'b0, fl_pr1}, 8'd35);
    check("flush_count", {1'b0, fl_free_count}, 8'd64);
    step(0, 0, 7'd0, 7'd0, 1'b0);

    // Long random run: pointers wrap several times, FIFO order is checked.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      d  = $urandom_range(0, 3);
      mr = (m_alloc.size() >= 2) ? 2 : m_alloc.size();
      r  = $urandom_range(0, mr);
      if (r == 2 && $urandom_range(0, 1) == 1) r = 3;
      ta = (mr >= 1) ? m_alloc[0] : 7'd0;
      tb = (mr >= 2) ? m_alloc[1] : 7'd0;
      f  = ($urandom_range(0, 31) == 0);
      step(d, r, ta, tb, f);
    end

    // Overflow: retire into a full list, sticky until reset.
    do_reset();
    step(0, 1, 7'd9, 7'd0, 1'b0);
    settle();
    check("ovf_set",   {7'd0, fl_overflow}, 8'd1);
    check("ovf_count", {1'b0, fl_free_count}, 8'd64);
    check("ovf_pr0",   {1'b0, fl_pr0}, 8'd32);
    step(2, 0, 7'd0, 7'd0, 1'b0);
    step(1, 0, 7'd0, 7'd0, 1'b0);
    settle();
    check("ovf_sticky", {7'd0, fl_overflow}, 8'd1);

    // Reset mid-operation restores everything.
    do_reset();
    settle();
    check("rst2_ovf",   {7'd0, fl_overflow}, 8'd0);
    check("rst2_count", {1'b0, fl_free_count}, 8'd64);
    check("rst2_pr0",   {1'b0, fl_pr0}, 8'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
